// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: two-requester sequential adder controller.
// A single 4-bit ripple-carry slice is reused over four cycles to form a
// 16-bit unsigned sum. Requests are arbitrated round-robin in IDLE only.
//
// State table
//   state | meaning
//   IDLE  | waiting for req0/req1, no grant
//   ADD   | one nibble per cycle, idx 0..3
//   DONE  | result valid, done pulse, grant released on exit
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   req0/req1           : add requests
//   a0,b0,cin0          : operands of requester 0
//   a1,b1,cin1          : operands of requester 1
//   gnt0/gnt1           : current owner of the adder
//   busy, done          : operation in progress, completion pulse
//   owner, sum, cout    : result of the most recent completed operation
module rca_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        cin0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        cin1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        owner,
    output logic [15:0] sum,
    output logic        cout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [15:0] work_q, work_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        gsel_q, gsel_d;
    logic        last_q, last_d;
    logic [15:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        owner_q, owner_d;

    logic [3:0]  a_nib, b_nib, nib_s;
    logic [4:0]  rc;
    logic [15:0] work_nxt;
    logic        pick;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];

    // The only adder in the block: a 4-bit ripple chain of full adders.
    always_comb begin
        rc    = '0;
        nib_s = '0;
        rc[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            nib_s[i] = a_nib[i] ^ b_nib[i] ^ rc[i];
            rc[i+1]  = (a_nib[i] & b_nib[i]) | (rc[i] & (a_nib[i] ^ b_nib[i]));
        end
    end

    always_comb begin
        work_nxt = work_q;
        work_nxt[{idx_q, 2'b00} +: 4] = nib_s;
    end

    // On a tie the requester not served last wins; otherwise whoever asks.
    assign pick = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        work_d  = work_q;
        a_d     = a_q;
        b_d     = b_q;
        gsel_d  = gsel_q;
        last_d  = last_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    gsel_d  = pick;
                    a_d     = pick ? a1 : a0;
                    b_d     = pick ? b1 : b0;
                    carry_d = pick ? cin1 : cin0;
                    idx_d   = 2'd0;
                    work_d  = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                work_d  = work_nxt;
                carry_d = rc[4];
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    sum_d   = work_nxt;
                    cout_d  = rc[4];
                    owner_d = gsel_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = gsel_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gsel_q  <= 1'b0;
            last_q  <= 1'b1;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gsel_q  <= gsel_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            owner_q <= owner_d;
        end
    end

    assign busy  = (state_q == ST_ADD) || (state_q == ST_DONE);
    assign done  = (state_q == ST_DONE);
    assign gnt0  = busy && !gsel_q;
    assign gnt1  = busy && gsel_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
module tb_rca_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        cin0, cin1;
    logic        gnt0, gnt1, busy, done, owner, cout;
    logic [15:0] sum;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        last_served;
    logic [15:0] m_sum;
    logic        m_cout;
    logic        m_owner;

    rca_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .cin0(cin0),
        .a1(a1), .b1(b1), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .owner(owner), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1;
        logic [15:0] a0, b0;
        logic        c0;
        logic [15:0] a1, b1;
        logic        c1;
        logic [15:0] esum;
        logic        ecout;
        logic        eown;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        tick();
        tick();
        rst_n = 1'b1;
        last_served = 1'b1;
        m_sum = '0; m_cout = 1'b0; m_owner = 1'b0;
    endtask

    // One complete operation from IDLE through the edge leaving DONE.
    task automatic run_op(input logic r0, input logic r1,
                          input logic [15:0] va0, input logic [15:0] vb0, input logic vc0,
                          input logic [15:0] va1, input logic [15:0] vb1, input logic vc1,
                          input logic eown, input logic [15:0] esum, input logic ecout,
                          input string tag);
        int n;
        req0 = r0; req1 = r1;
        a0 = va0; b0 = vb0; cin0 = vc0;
        a1 = va1; b1 = vb1; cin1 = vc1;
        tick();                                   // E0
        check({tag, "_gnt0"}, gnt0, !eown);
        check({tag, "_gnt1"}, gnt1, eown);
        check({tag, "_busy"}, busy, 1'b1);
        // Later changes must be ignored.
        req0 = 0; req1 = 0;
        a0 = ~va0; b0 = vb0 ^ 16'h5A5A; cin0 = ~vc0;
        a1 = ~va1; b1 = vb1 ^ 16'hA5A5; cin1 = ~vc1;
        n = 0;
        while (!done && n < 8) begin
            check({tag, "_hold_sum"}, sum, m_sum);
            tick();
            n++;
        end
        check({tag, "_done_latency"}, n, 4);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_owner"}, owner, eown);
        check({tag, "_done_gnt"}, {gnt1, gnt0}, eown ? 2'b10 : 2'b01);
        tick();                                   // E5
        check({tag, "_release"}, {busy, done, gnt1, gnt0}, 4'b0000);
        last_served = eown;
        m_sum = esum; m_cout = ecout; m_owner = eown;
    endtask

    initial begin
        int k;
        int dcnt;
        int dcyc[4];
        logic down[4];
        logic [15:0] dsum[4];

        rst_n = 0; req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; cin0 = 0; cin1 = 0;

        vecs[0] = '{1, 0, 16'h0003, 16'h0001, 0, 16'h0000, 16'h0000, 0, 16'h0004, 0, 0};
        vecs[1] = '{0, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 1};
        vecs[2] = '{1, 0, 16'h8000, 16'h8000, 1, 16'h0000, 16'h0000, 0, 16'h0001, 1, 0};
        vecs[3] = '{0, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1, 1};
        vecs[4] = '{1, 0, 16'hFFFF, 16'h0000, 1, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0};
        vecs[5] = '{0, 1, 16'h0000, 16'h0000, 0, 16'h0F0F, 16'hF0F0, 0, 16'hFFFF, 0, 1};
        vecs[6] = '{1, 0, 16'h1234, 16'h4321, 0, 16'h0000, 16'h0000, 0, 16'h5555, 0, 0};

        do_reset();
        check("reset_outputs", {gnt0, gnt1, busy, done, owner, cout}, 6'b0);
        check("reset_sum", sum, 16'h0000);

        // Directed table
        foreach (vecs[i])
            run_op(vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].b0, vecs[i].c0,
                   vecs[i].a1, vecs[i].b1, vecs[i].c1,
                   vecs[i].eown, vecs[i].esum, vecs[i].ecout, $sformatf("vec%0d", i));

        // Tie after reset with both requests held
        do_reset();
        req0 = 1; req1 = 1;
        a0 = 16'h0001; b0 = 16'h0001; cin0 = 0;
        a1 = 16'h0002; b1 = 16'h0002; cin1 = 0;
        dcnt = 0;
        for (int c = 1; c <= 40 && dcnt < 4; c++) begin
            tick();
            if (done) begin
                dcyc[dcnt] = c; down[dcnt] = owner; dsum[dcnt] = sum;
                dcnt++;
            end
        end
        req0 = 0; req1 = 0;
        check("tie_done_count", dcnt, 4);
        if (dcnt == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("tie_owner%0d", i), down[i], i % 2);
                check($sformatf("tie_sum%0d", i), dsum[i], (i % 2) ? 16'h0004 : 16'h0002);
            end
            check("tie_first_latency", dcyc[0], 5);
            for (int i = 1; i < 4; i++)
                check($sformatf("tie_gap%0d", i), dcyc[i] - dcyc[i-1], 6);
        end
        tick();
        check("tie_idle", busy, 1'b0);
        last_served = 1'b1; m_sum = 16'h0004; m_cout = 1'b0; m_owner = 1'b1;

        // Single requester held, operands changed after E0
        req1 = 1; a1 = 16'h1234; b1 = 16'h1111; cin1 = 0;
        tick();
        check("single_gnt1", {gnt1, gnt0}, 2'b10);
        a1 = 16'h0F0F; b1 = 16'h0101;
        k = 0;
        while (!done && k < 8) begin tick(); k++; end
        check("single_first_sum", sum, 16'h2345);
        check("single_first_owner", owner, 1'b1);
        tick();
        k = 0;
        while (!done && k < 10) begin tick(); k++; end
        check("single_second_wait", k, 5);
        check("single_second_sum", sum, 16'h1010);
        check("single_second_gnt", {gnt1, gnt0}, 2'b10);
        req1 = 0;
        tick();
        last_served = 1'b1; m_sum = 16'h1010; m_cout = 1'b0; m_owner = 1'b1;

        // Reset in the middle of an operation
        req0 = 1; a0 = 16'h0005; b0 = 16'h0006; cin0 = 0;
        tick();                                   // E0
        tick();                                   // E1
        rst_n = 0;
        tick();                                   // E2 under reset
        check("midrst_flags", {gnt0, gnt1, busy, done}, 4'b0000);
        check("midrst_sum", sum, 16'h0000);
        check("midrst_owner_cout", {owner, cout}, 2'b00);
        tick();                                   // request present, reset wins
        check("midrst_priority", {busy, gnt0}, 2'b00);
        rst_n = 1; req0 = 0;
        last_served = 1'b1; m_sum = '0; m_cout = 1'b0; m_owner = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (done) k++; end
        check("midrst_no_done", k, 0);
        run_op(1, 0, 16'h0007, 16'h0008, 0, 0, 0, 0, 0, 16'h000F, 0, "after_rst");

        // Randomised against the arithmetic/arbitration model
        for (int it = 0; it < 40; it++) begin
            logic r0, r1, c0, c1, own, ecout;
            logic [15:0] ra0, rb0, ra1, rb1, esum;
            logic [16:0] full;
            int rr;
            rr = $urandom_range(1, 3);
            r0 = rr[0]; r1 = rr[1];
            ra0 = 16'($urandom); rb0 = 16'($urandom); c0 = 1'($urandom);
            ra1 = 16'($urandom); rb1 = 16'($urandom); c1 = 1'($urandom);
            if (it % 8 == 0) begin ra0 = 16'hFFFF; ra1 = 16'hFFFF; end
            own = (r0 && r1) ? !last_served : r1;
            full = own ? (17'(ra1) + 17'(rb1) + 17'(c1)) : (17'(ra0) + 17'(rb0) + 17'(c0));
            esum = full[15:0]; ecout = full[16];
            run_op(r0, r1, ra0, rb0, c0, ra1, rb1, c1, own, esum, ecout,
                   $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
